// File: rtl/sense_rate_controller.sv
// Sense-rate lock controller: times intervals between filtered edges, classifies
// them good/bad from filter violations, and tracks acquire/lock/loss of the sensed rate.
package clks_alot_p;
  localparam int COUNTER_WIDTH = 8;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] max_half;
    logic [COUNTER_WIDTH-1:0] min_half;
  } half_rate_limits_s;
endpackage

module sense_rate_controller #(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           enable_i,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  input  clks_alot_p::half_rate_limits_s cfg_limits_i,
  input  logic                           cfg_polarity_en_i,
  input  logic                           cfg_polarity_i,
  output clks_alot_p::half_rate_limits_s filter_limits_o,
  output logic                           filter_polarity_en_o,
  output logic                           filter_polarity_o,
  output logic [COUNTER_WIDTH-1:0]       rate_counter_o,
  input  logic                           filtered_event_i,
  input  logic                           over_violation_i,
  input  logic                           under_violation_i,
  output logic [COUNTER_WIDTH-1:0]       half_period_o,
  output logic                           half_period_valid_o,
  output logic                           locked_o,
  output logic                           lost_o,
  output logic [1:0]                     state_o
);

  // state    | meaning
  // IDLE     | disabled, everything held clear
  // ACQUIRE  | aligning, then counting consecutive good intervals
  // LOCKED   | rate tracked, counting consecutive bad intervals
  // LOST     | one-cycle loss notification, then back to ACQUIRE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  localparam logic [3:0] LP_LOCK = 4'(LOCK_COUNT);
  localparam logic [3:0] LP_LOSS = 4'(LOSS_COUNT);

  state_e                         r_state, w_state_nxt;
  logic [COUNTER_WIDTH-1:0]       r_cnt, w_cnt_nxt;
  logic [3:0]                     r_good, w_good_nxt;
  logic [3:0]                     r_bad, w_bad_nxt;
  logic                           r_sticky, w_sticky_nxt;
  logic                           r_align, w_align_nxt;
  logic [COUNTER_WIDTH-1:0]       r_half;
  logic                           r_half_valid;
  clks_alot_p::half_rate_limits_s r_limits;
  logic                           r_pol_en;
  logic                           r_pol;

  logic w_cfg_ready;
  logic w_xfer;
  logic w_viol;
  logic w_close;
  logic w_good_iv;
  logic w_meas;

  assign w_cfg_ready = (r_state == ST_IDLE) || (r_state == ST_ACQUIRE);
  assign w_xfer      = cfg_valid_i && w_cfg_ready;
  assign w_viol      = over_violation_i | under_violation_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_good       <= '0;
      r_bad        <= '0;
      r_sticky     <= 1'b0;
      r_align      <= 1'b1;
      r_half       <= '0;
      r_half_valid <= 1'b0;
      r_limits     <= '0;
      r_pol_en     <= 1'b0;
      r_pol        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_good       <= w_good_nxt;
      r_bad        <= w_bad_nxt;
      r_sticky     <= w_sticky_nxt;
      r_align      <= w_align_nxt;
      r_half_valid <= w_meas;
      if (w_meas) r_half <= r_cnt;
      if (w_xfer) begin
        r_limits <= cfg_limits_i;
        r_pol_en <= cfg_polarity_en_i;
        r_pol    <= cfg_polarity_i;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_good_nxt   = r_good;
    w_bad_nxt    = r_bad;
    w_sticky_nxt = r_sticky;
    w_align_nxt  = r_align;
    w_close      = 1'b0;
    w_good_iv    = 1'b0;
    w_meas       = 1'b0;

    if (!enable_i || (r_state == ST_IDLE)) begin
      w_state_nxt  = enable_i ? ST_ACQUIRE : ST_IDLE;
      w_cnt_nxt    = '0;
      w_good_nxt   = '0;
      w_bad_nxt    = '0;
      w_sticky_nxt = 1'b0;
      w_align_nxt  = 1'b1;
    end else if (w_xfer) begin
      // new filter settings invalidate the current interval, so restart cleanly
      w_cnt_nxt    = '0;
      w_good_nxt   = '0;
      w_bad_nxt    = '0;
      w_sticky_nxt = 1'b0;
      w_align_nxt  = 1'b1;
    end else begin
      if (filtered_event_i) begin
        w_meas       = 1'b1;
        w_close      = 1'b1;
        w_good_iv    = !(r_sticky || w_viol);
        w_cnt_nxt    = '0;
        w_sticky_nxt = 1'b0;
      end else if (&r_cnt) begin
        w_close      = 1'b1;
        w_cnt_nxt    = '0;
        w_sticky_nxt = 1'b0;
      end else begin
        w_cnt_nxt    = r_cnt + 1'b1;
        w_sticky_nxt = r_sticky | w_viol;
      end

      case (r_state)
        ST_ACQUIRE: begin
          if (w_close) begin
            if (r_align && filtered_event_i) begin
              w_align_nxt = 1'b0;
            end else if (w_good_iv) begin
              w_good_nxt = r_good + 1'b1;
              if (w_good_nxt == LP_LOCK) begin
                w_state_nxt = ST_LOCKED;
                w_bad_nxt   = '0;
              end
            end else begin
              w_good_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_close) begin
            if (w_good_iv) begin
              w_bad_nxt = '0;
            end else begin
              w_bad_nxt = r_bad + 1'b1;
              if (w_bad_nxt == LP_LOSS) w_state_nxt = ST_LOST;
            end
          end
        end
        ST_LOST: begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
          w_align_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready_o          = w_cfg_ready;
  assign filter_limits_o      = r_limits;
  assign filter_polarity_en_o = r_pol_en;
  assign filter_polarity_o    = r_pol;
  assign rate_counter_o       = r_cnt;
  assign half_period_o        = r_half;
  assign half_period_valid_o  = r_half_valid;
  assign locked_o             = (r_state == ST_LOCKED);
  assign lost_o               = (r_state == ST_LOST);
  assign state_o              = r_state;

endmodule
